// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;
    localparam int unsigned RESET_PC_DEFAULT  = 0;
    localparam int unsigned PC_INCR           = 4;

    // Where the IF/ID register takes its next contents from.
    typedef enum logic [1:0] {
        SRC_BUBBLE,
        SRC_FETCH,
        SRC_HOLD
    } ifid_src_e;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read port: strobe/address out, data back one cycle later.
interface if_stage_if #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned WORD_SIZE = 32
);
    logic                 imem_en;
    logic [ADDR_SIZE-1:0] imem_addr;
    logic [WORD_SIZE-1:0] imem_rdata;

    modport master (output imem_en, output imem_addr, input imem_rdata);
    modport slave  (input imem_en, input imem_addr, output imem_rdata);
endinterface

// File: rtl/if_hold_buf.sv
// One-entry capture/release buffer for a fetched word that decode could not accept.
module if_hold_buf #(
    parameter int unsigned ADDR_SIZE = 10,
    parameter int unsigned WORD_SIZE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 capture,
    input  logic                 drain,
    input  logic [ADDR_SIZE-1:0] in_pc,
    input  logic [WORD_SIZE-1:0] in_instr,
    output logic                 hold_valid_q,
    output logic [ADDR_SIZE-1:0] hold_pc_q,
    output logic [WORD_SIZE-1:0] hold_instr_q
);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            hold_valid_q <= 1'b0;
        end else if (capture) begin
            hold_valid_q <= 1'b1;
            hold_pc_q    <= in_pc;
            hold_instr_q <= in_instr;
        end else if (drain) begin
            hold_valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, imem request, hold buffer and IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = 32,
    parameter int unsigned          ADDR_SIZE = 10,
    parameter int unsigned          RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [ADDR_SIZE-1:0] redirect_pc,
    if_stage_if.master           imem,
    output logic [ADDR_SIZE-1:0] pc_out,
    output logic [WORD_SIZE-1:0] instr_out,
    output logic                 valid_out
);

    localparam logic [ADDR_SIZE-1:0] INCR       = ADDR_SIZE'(PC_INCR);
    localparam logic [ADDR_SIZE-1:0] ALIGN_MASK = ~ADDR_SIZE'(3);

    logic [ADDR_SIZE-1:0] pc_q;
    logic [ADDR_SIZE-1:0] f_pc_q;
    logic                 f_valid_q;
    logic                 hold_valid_q;
    logic [ADDR_SIZE-1:0] hold_pc_q;
    logic [WORD_SIZE-1:0] hold_instr_q;
    logic [ADDR_SIZE-1:0] target;
    ifid_src_e            src;
    logic [ADDR_SIZE-1:0] next_pc;
    logic [WORD_SIZE-1:0] next_instr;
    logic                 next_valid;

    assign target = redirect_pc & ALIGN_MASK;

    always_comb begin
        imem.imem_en   = ~rst & (redirect | ~stall);
        imem.imem_addr = redirect ? target : pc_q;
    end

    // Hold buffer fills only while no fetch is issued, so it never competes with f_valid_q.
    if_hold_buf #(
        .ADDR_SIZE (ADDR_SIZE),
        .WORD_SIZE (WORD_SIZE)
    ) u_hold (
        .clk          (clk),
        .rst          (rst),
        .flush        (redirect),
        .capture      (stall & ~redirect & f_valid_q),
        .drain        (~stall & ~redirect & hold_valid_q),
        .in_pc        (f_pc_q),
        .in_instr     (imem.imem_rdata),
        .hold_valid_q (hold_valid_q),
        .hold_pc_q    (hold_pc_q),
        .hold_instr_q (hold_instr_q)
    );

    always_comb begin
        src = SRC_BUBBLE;
        if (hold_valid_q) begin
            src = SRC_HOLD;
        end else if (f_valid_q) begin
            src = SRC_FETCH;
        end
    end

    always_comb begin
        next_pc    = pc_out;
        next_instr = NOP_INSTR;
        next_valid = 1'b0;
        case (src)
            SRC_HOLD: begin
                next_pc    = hold_pc_q;
                next_instr = hold_instr_q;
                next_valid = 1'b1;
            end
            SRC_FETCH: begin
                next_pc    = f_pc_q;
                next_instr = imem.imem_rdata;
                next_valid = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= ADDR_SIZE'(RESET_PC);
            f_pc_q    <= '0;
            f_valid_q <= 1'b0;
            pc_out    <= '0;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (redirect) begin
            pc_q      <= target + INCR;
            f_pc_q    <= target;
            f_valid_q <= 1'b1;
            instr_out <= NOP_INSTR;
            valid_out <= 1'b0;
        end else if (!stall) begin
            pc_q      <= pc_q + INCR;
            f_pc_q    <= pc_q;
            f_valid_q <= 1'b1;
            pc_out    <= next_pc;
            instr_out <= next_instr;
            valid_out <= next_valid;
        end else begin
            f_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomised + directed bench for if_stage against a queue-based fetch-stream model.
module tb_if_stage;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stall = 1'b0;
    logic          redirect = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] instr_out;
    logic          valid_out;

    int n_tests = 0;
    int n_fail  = 0;

    if_stage_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) imem ();

    if_stage #(
        .WORD_SIZE (DW),
        .ADDR_SIZE (AW),
        .RESET_PC  (0),
        .NOP_INSTR (NOP)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem        (imem.master),
        .pc_out      (pc_out),
        .instr_out   (instr_out),
        .valid_out   (valid_out)
    );

    always #5 clk = ~clk;

    initial imem.imem_rdata = '0;
    always @(posedge clk)
        if (imem.imem_en) imem.imem_rdata <= 32'hA000_0000 | {22'b0, imem.imem_addr};

    // Model: queue of fetched-but-not-emitted PCs plus the next fetch address.
    logic [AW-1:0] pend[$];
    logic [AW-1:0] m_next  = '0;
    logic [AW-1:0] m_pc    = '0;
    logic [31:0]   m_instr = NOP;
    logic          m_valid = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle(input logic r, input logic s, input logic rd, input logic [AW-1:0] rpc);
        logic [AW-1:0] tgt;
        logic [AW-1:0] p;
        rst = r; stall = s; redirect = rd; redirect_pc = rpc;
        tgt = rpc & 10'h3FC;
        #1;
        check("imem_en", {31'b0, imem.imem_en}, {31'b0, ~r & (rd | ~s)});
        if (!r && (rd || !s))
            check("imem_addr", {22'b0, imem.imem_addr}, {22'b0, rd ? tgt : m_next});
        @(posedge clk);
        if (r) begin
            pend.delete();
            m_next = '0; m_pc = '0; m_instr = NOP; m_valid = 1'b0;
        end else if (rd) begin
            pend.delete();
            pend.push_back(tgt);
            m_next = tgt + 10'd4; m_instr = NOP; m_valid = 1'b0;
        end else if (!s) begin
            if (pend.size() > 0) begin
                p = pend.pop_front();
                m_pc = p; m_instr = 32'hA000_0000 | {22'b0, p}; m_valid = 1'b1;
            end else begin
                m_instr = NOP; m_valid = 1'b0;
            end
            pend.push_back(m_next);
            m_next = m_next + 10'd4;
        end
        @(negedge clk);
        check("valid_out", {31'b0, valid_out}, {31'b0, m_valid});
        check("instr_out", instr_out, m_instr);
        check("pc_out", {22'b0, pc_out}, {22'b0, m_pc});
    endtask

    initial begin
        @(negedge clk);
        cycle(1, 0, 0, '0);
        cycle(1, 1, 0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 10'h100);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(0, 1, 1, 10'h040);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 10'h3FC);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
        cycle(0, 0, 1, 10'h102);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(0, 1, 0, '0);
        cycle(1, 1, 0, '0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0);
        for (int i = 0; i < 400; i++) begin
            automatic logic r  = ($urandom_range(0, 99) < 2);
            automatic logic s  = ($urandom_range(0, 99) < 30);
            automatic logic rd = ($urandom_range(0, 99) < 10);
            cycle(r, s, rd, AW'($urandom_range(0, 1023)));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage that feeds the decode stage through the IF/ID pipeline register.
- Owns the PC and drives a synchronous instruction memory with 1-cycle read latency.
- Absorbs decode-side stalls with a one-entry hold buffer, so no fetched word is lost and throughput stays at one instruction per cycle.
- Applies EX-stage redirects (taken branch/jump) by discarding in-flight fetches and emitting bubbles.

Parameters:
WORD_SIZE, 32, instruction width
ADDR_SIZE, 10, PC / byte-address width
RESET_PC, 0, first fetch address after reset
NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0)

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
stall  in  1  hold IF/ID contents and PC (from hazard unit)
redirect  in  1  taken branch/jump from EX; flush and refetch
redirect_pc  in  ADDR_SIZE  redirect target
imem_en  out  1  memory read strobe
imem_addr  out  ADDR_SIZE  memory read address (byte)
imem_rdata  in  WORD_SIZE  read data, valid the cycle after imem_en
pc_out  out  ADDR_SIZE  IF/ID: PC of held instruction
instr_out  out  WORD_SIZE  IF/ID: instruction
valid_out  out  1  IF/ID: instruction is real (0 = bubble)

Behaviour:
- Clock and reset: single clock clk; rst is synchronous, active-high.
- Internal state:
  - pc_q: next fetch address.
  - f_pc_q / f_valid_q: fetch in flight.
  - hold_pc_q / hold_instr_q / hold_valid_q: one-entry hold buffer.
  - pc_out / instr_out / valid_out: IF/ID register.
- Reset values: pc_q=RESET_PC, f_valid_q=0, hold_valid_q=0, pc_out=0, instr_out=NOP_INSTR, valid_out=0.
- Alignment: redirect_pc[1:0] is forced to 2'b00. All PC arithmetic is pc+4 modulo 2^ADDR_SIZE; wraps silently.
- Combinational outputs:
  - imem_addr = redirect ? aligned redirect_pc : pc_q.
  - imem_en = redirect | ~stall.
  - imem_en=0 during rst.
- Redirect (highest priority; stall is ignored that cycle):
  - pc_q <= target+4; f_pc_q <= target; f_valid_q <= 1.
  - hold_valid_q <= 0.
  - valid_out <= 0, instr_out <= NOP_INSTR, pc_out unchanged.
  - Any imem_rdata arriving that cycle is discarded.
  - The target instruction reaches IF/ID 2 cycles after redirect.
- Normal cycle (~stall, ~redirect):
  - Issue fetch: f_pc_q <= pc_q, f_valid_q <= 1, pc_q <= pc_q+4.
  - IF/ID loads from the first available source, in priority order:
    1. hold buffer (then hold_valid_q <= 0);
    2. {f_pc_q, imem_rdata} if f_valid_q;
    3. otherwise a bubble (valid_out=0, instr_out=NOP_INSTR).
  - hold_valid_q and f_valid_q are never both set when unstalling, because the hold buffer is only filled while no fetch is issued.
- Stall cycle (stall, ~redirect):
  - No issue; pc_q and the IF/ID register hold.
  - If f_valid_q: hold buffer <= {f_pc_q, imem_rdata}, hold_valid_q <= 1, f_valid_q <= 0.
  - Further stall cycles change nothing.
- Latency and throughput:
  - Out of reset, the first valid_out occurs on the 2nd rising edge after rst deasserts.
  - Steady state: one instruction per cycle.
  - A stall of N cycles delays the stream by exactly N cycles, with no gap and no duplicate.
- Reset mid-operation: all in-flight and held words are dropped; fetching restarts at RESET_PC.
- Stall asserted during reset: no effect.

Decomposition:
- defines.vh: NOP_INSTR constant, RESET_PC default, PC_INCR (4).
- Optional sub-module if_hold_buf: one-entry capture/release register with valid bit and flush.
- PC register and IF/ID register stay in if_stage.
- Target size: about 150 RTL lines.

Test Plan:
1. Reset then free-run; memory returns word = 0xA000_0000|addr → imem_addr 0,4,8…; valid_out first high on edge 2 with pc_out=0, instr 0xA0000000; then pc_out 4, 8 on consecutive cycles.
2. Stall for 3 cycles while pc_out=8 → pc_out/instr hold at 8 for 3 cycles; imem_en=0; next cycles output 12, 16 with no gap or duplicate.
3. Redirect to 0x100 while pc_out=16 → next cycle valid_out=0, instr_out=0x00000013; following cycle pc_out=0x100; word for 20 never appears.
4. Redirect and stall asserted together (target 0x040) → redirect wins; imem_addr=0x040 that cycle; hold buffer cleared; pc_out=0x040 two cycles later.
5. Redirect to 0x3FC with ADDR_SIZE=10 → pc_out 0x3FC then 0x000 (wrap). Redirect_pc=0x102 → fetch at 0x100.
6. Assert rst during a stall with hold buffer full → valid_out=0 next cycle; fetch restarts at RESET_PC; held word never emitted.
